// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MULTI,
    ST_RELEASE
  } state_e;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam int unsigned MUL_LAT_DEF = 4;

  // r0 is hardwired to zero, so it can never carry a true dependency.
  function automatic logic reg_match(input logic [4:0] d,
                                     input logic [4:0] s1,
                                     input logic [4:0] s2,
                                     input logic       two_src);
    return (d != REG_ZERO) && ((d == s1) || (two_src && (d == s2)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status in, stage controls and counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic [4:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [4:0]       mem_dest;
  logic             mem_wb_en;
  logic             exe_multi;
  logic             branch_taken;
  logic             mem_busy;
  logic             hold_pc;
  logic             hold_ifid;
  logic             bubble_idex;
  logic             flush;
  logic             freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, exe_multi, branch_taken, mem_busy,
    input  hold_pc, hold_ifid, bubble_idex, flush, freeze, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, exe_multi, branch_taken, mem_busy,
    output hold_pc, hold_ifid, bubble_idex, flush, freeze, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/bubble/flush/freeze generation with saturating stall and flush counters.
// Build option PIPE_FWD_EN: forwarding present, only load-use hazards stall.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  // The RUN cycle that sees exe_multi is the first freeze cycle, hence the -2.
  localparam logic [3:0] MUL_LOAD = (MUL_LAT >= 2) ? 4'(MUL_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hz;
  logic       freeze, flush, bubble, hold;

  always_comb begin
`ifdef PIPE_FWD_EN
    hz = bus.exe_mem_r_en &&
         reg_match(bus.exe_dest, bus.id_src1, bus.id_src2, bus.id_two_src);
`else
    hz = (bus.exe_mem_r_en &&
          reg_match(bus.exe_dest, bus.id_src1, bus.id_src2, bus.id_two_src)) ||
         (bus.exe_wb_en &&
          reg_match(bus.exe_dest, bus.id_src1, bus.id_src2, bus.id_two_src)) ||
         (bus.mem_wb_en &&
          reg_match(bus.mem_dest, bus.id_src1, bus.id_src2, bus.id_two_src));
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.exe_multi) begin
          cnt_d   = MUL_LOAD;
          state_d = (MUL_LAT == 1) ? ST_RELEASE : ST_MULTI;
        end
      end
      ST_MULTI: begin
        if (cnt_q == '0) state_d = ST_RELEASE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_RELEASE: begin
        if (!bus.mem_busy) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Freeze outranks a taken branch, which outranks a hazard bubble.
  always_comb begin
    freeze = 1'b0;
    flush  = 1'b0;
    bubble = 1'b0;
    if (!rst) begin
      freeze = bus.mem_busy || (state_q == ST_MULTI) ||
               ((state_q == ST_RUN) && bus.exe_multi);
      if (!freeze) begin
        if (bus.branch_taken) flush  = 1'b1;
        else if (hz)          bubble = 1'b1;
      end
    end
  end

  assign hold            = freeze || bubble;
  assign bus.hold_pc     = hold;
  assign bus.hold_ifid   = hold;
  assign bus.bubble_idex = bubble;
  assign bus.flush       = flush;
  assign bus.freeze      = freeze;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hold),
    .count_o (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush),
    .count_o (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; narrow counters make saturation reachable.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       two;
    logic [4:0] ed;
    logic       ewb;
    logic       emr;
    logic [4:0] md;
    logic       mwb;
    logic       multi;
    logic       br;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic [4:0]       ctl;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] fl;
  } exp_t;

  typedef struct packed {
    stim_t      s;
    logic [4:0] x;
  } step_t;

  // ctl = {hold_pc, hold_ifid, bubble_idex, flush, freeze}
  localparam logic [4:0] C0  = 5'b00000;
  localparam logic [4:0] FRZ = 5'b11001;
  localparam logic [4:0] BUB = 5'b11100;
  localparam logic [4:0] FL  = 5'b00010;
  localparam stim_t      IDLE = '0;
`ifdef PIPE_FWD_EN
  localparam logic [4:0] RAW = C0;
`else
  localparam logic [4:0] RAW = BUB;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [4:0] ctl_o;
  assign ctl_o = {bus.hold_pc, bus.hold_ifid, bus.bubble_idex, bus.flush, bus.freeze};

  exp_t             sb[$];
  int unsigned      errors = 0;
  int unsigned      checks = 0;
  logic [CNT_W-1:0] acc_st = '0;
  logic [CNT_W-1:0] acc_fl = '0;

  function automatic stim_t ld(input logic [4:0] ed, input logic [4:0] s1,
                               input logic [4:0] s2, input logic two);
    stim_t t;
    t = IDLE; t.emr = 1'b1; t.ed = ed; t.s1 = s1; t.s2 = s2; t.two = two;
    return t;
  endfunction

  // Apply one cycle of stimulus and queue the outputs expected at its sample point.
  task automatic drive(input stim_t s, input logic [4:0] ctl);
    rst              = s.rst;
    bus.id_src1      = s.s1;
    bus.id_src2      = s.s2;
    bus.id_two_src   = s.two;
    bus.exe_dest     = s.ed;
    bus.exe_wb_en    = s.ewb;
    bus.exe_mem_r_en = s.emr;
    bus.mem_dest     = s.md;
    bus.mem_wb_en    = s.mwb;
    bus.exe_multi    = s.multi;
    bus.branch_taken = s.br;
    bus.mem_busy     = s.busy;
    sb.push_back('{ctl: ctl, st: acc_st, fl: acc_fl});
    if (s.rst) begin
      acc_st = '0;
      acc_fl = '0;
    end else begin
      if (ctl[4] && (acc_st != '1)) acc_st = acc_st + 1'b1;
      if (ctl[1] && (acc_fl != '1)) acc_fl = acc_fl + 1'b1;
    end
  endtask

  task automatic test_reset();
    step_t q[$];
    stim_t t;
    exp_t  e;
    t = IDLE; t.multi = 1'b1;
    q.push_back('{t, FRZ});
    q.push_back('{t, FRZ});
    t.rst = 1'b1; t.busy = 1'b1; t.br = 1'b1;
    q.push_back('{t, C0});
    q.push_back('{IDLE, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL reset[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
        errors++; $display("FAIL reset[%0d] cnt got=%0d/%0d exp=%0d/%0d", i,
                           bus.stall_cnt, bus.flush_cnt, e.st, e.fl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t q[$];
    exp_t  e;
    q.push_back('{ld(5, 5, 0, 1'b0), BUB});
    q.push_back('{IDLE, C0});
    q.push_back('{ld(5, 0, 5, 1'b0), C0});
    q.push_back('{ld(5, 0, 5, 1'b1), BUB});
    q.push_back('{ld(5, 4, 6, 1'b1), C0});
    q.push_back('{IDLE, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL load_use[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
        errors++; $display("FAIL load_use[%0d] cnt got=%0d/%0d exp=%0d/%0d", i,
                           bus.stall_cnt, bus.flush_cnt, e.st, e.fl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    step_t q[$];
    stim_t t;
    exp_t  e;
    q.push_back('{ld(0, 0, 0, 1'b1), C0});
    t = IDLE; t.ewb = 1'b1; t.mwb = 1'b1; t.two = 1'b1;
    q.push_back('{t, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL zero_reg[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    step_t q[$];
    stim_t t;
    exp_t  e;
    t = ld(7, 1, 7, 1'b1); t.br = 1'b1;
    q.push_back('{t, FL});
    q.push_back('{IDLE, C0});
    t.busy = 1'b1;
    q.push_back('{t, FRZ});
    q.push_back('{IDLE, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL branch[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
        errors++; $display("FAIL branch[%0d] cnt got=%0d/%0d exp=%0d/%0d", i,
                           bus.stall_cnt, bus.flush_cnt, e.st, e.fl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi();
    step_t q[$];
    stim_t m, mh;
    exp_t  e;
    m  = IDLE; m.multi = 1'b1;
    mh = ld(5, 5, 0, 1'b0); mh.multi = 1'b1;
    q.push_back('{m, FRZ});
    q.push_back('{m, FRZ});
    q.push_back('{mh, FRZ});
    q.push_back('{m, FRZ});
    q.push_back('{m, C0});
    for (int unsigned k = 0; k < 4; k++) q.push_back('{m, FRZ});
    q.push_back('{IDLE, C0});
    q.push_back('{IDLE, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL multi[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
        errors++; $display("FAIL multi[%0d] cnt got=%0d/%0d exp=%0d/%0d", i,
                           bus.stall_cnt, bus.flush_cnt, e.st, e.fl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    step_t q[$];
    stim_t m, mb, mbx;
    exp_t  e;
    m   = IDLE; m.multi = 1'b1;
    mb  = m;    mb.busy = 1'b1;
    mbx = ld(5, 5, 0, 1'b0); mbx.multi = 1'b1; mbx.busy = 1'b1; mbx.br = 1'b1;
    q.push_back('{m, FRZ});
    q.push_back('{m, FRZ});
    q.push_back('{mb, FRZ});
    q.push_back('{mb, FRZ});
    for (int unsigned k = 0; k < 4; k++) q.push_back('{mbx, FRZ});
    q.push_back('{m, C0});
    q.push_back('{IDLE, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL mem_wait[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
        errors++; $display("FAIL mem_wait[%0d] cnt got=%0d/%0d exp=%0d/%0d", i,
                           bus.stall_cnt, bus.flush_cnt, e.st, e.fl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd();
    step_t q[$];
    stim_t t;
    exp_t  e;
    t = IDLE; t.mwb = 1'b1; t.md = 3; t.s1 = 3;
    q.push_back('{t, RAW});
    t = IDLE; t.ewb = 1'b1; t.ed = 9; t.s2 = 9; t.two = 1'b1;
    q.push_back('{t, RAW});
    q.push_back('{IDLE, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL fwd[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    step_t q[$];
    stim_t t;
    exp_t  e;
    t = IDLE; t.rst = 1'b1;
    q.push_back('{t, C0});
    for (int unsigned k = 0; k < 18; k++) q.push_back('{ld(5, 5, 0, 1'b0), BUB});
    t = IDLE; t.br = 1'b1;
    for (int unsigned k = 0; k < 17; k++) q.push_back('{t, FL});
    q.push_back('{IDLE, C0});
    foreach (q[i]) begin
      drive(q[i].s, q[i].x);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_o !== e.ctl) begin
        errors++; $display("FAIL saturate[%0d] ctl got=%b exp=%b", i, ctl_o, e.ctl);
      end
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
        errors++; $display("FAIL saturate[%0d] cnt got=%0d/%0d exp=%0d/%0d", i,
                           bus.stall_cnt, bus.flush_cnt, e.st, e.fl);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    stim_t t;
    exp_t  e;
    t = IDLE; t.rst = 1'b1;
    drive(t, C0);
    @(posedge clk); #1;
    e = sb.pop_front();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_multi();
    test_mem_wait();
    test_fwd();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates the hold, bubble, flush and freeze controls for the PC, IF/ID and ID/EX stage registers.
- Covers load-use and RAW hazards, taken branches resolved in EXE, external memory wait, and multi-cycle EXE ops (multiplier).
- Keeps saturating stall and flush performance counters.

Parameters:
- MUL_LAT, 4, cycles the multi-cycle EXE unit needs; legal range 1..16.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src1  in  5  rs of the instruction in ID.
- id_src2  in  5  rt of the instruction in ID.
- id_two_src  in  1  ID instruction reads id_src2.
- exe_dest  in  5  destination register of the EXE instruction.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_dest  in  5  destination register of the MEM instruction.
- mem_wb_en  in  1  MEM instruction writes back.
- exe_multi  in  1  EXE holds a multi-cycle op.
- branch_taken  in  1  branch resolved taken in EXE.
- mem_busy  in  1  data memory not ready.
- hold_pc  out  1  PC keeps its value.
- hold_ifid  out  1  IF/ID register keeps its value.
- bubble_idex  out  1  zero control fields entering ID/EX.
- flush  out  1  clear IF/ID and ID/EX (drives ID/EX branch_taken input).
- freeze  out  1  every stage register holds (drives ID/EX stall input).
- stall_cnt  out  CNT_W  cycles with hold_pc=1.
- flush_cnt  out  CNT_W  number of flush pulses.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port rst. rst has top priority.
- Reset values: state=RUN, mul counter=0, stall_cnt=0, flush_cnt=0. While rst=1 all control outputs are 0.
- Control outputs are combinational from registered state and current inputs. Zero latency: asserted in the same cycle as the cause.
- Register 0 never causes a hazard.
- Match definition: match(d) = d!=0 && (d==id_src1 || (id_two_src && d==id_src2)).
- Hazard: hz = exe_mem_r_en && match(exe_dest), plus the additional terms listed under Optional Feature.
- Output priority, highest first:
  - freeze = mem_busy || state==MULTI || (state==RUN && exe_multi).
  - If freeze=1: flush=0 and bubble_idex=0.
  - Else if branch_taken: flush=1, bubble_idex=0. Hazard is ignored because the ID instruction is squashed.
  - Else if hz: bubble_idex=1.
- hold_pc = hold_ifid = freeze || (bubble_idex).
- States:
  - RUN: if exe_multi and not rst: load cnt<=MUL_LAT-2 and go to MULTI. If MUL_LAT==1, go directly to RELEASE.
  - MULTI: freeze=1. If cnt==0 go to RELEASE, else cnt<=cnt-1. Counting continues while mem_busy=1; the multiplier is independent of memory.
  - RELEASE: exe_multi is ignored. freeze comes from mem_busy only. Stay in RELEASE while mem_busy=1, otherwise go to RUN. The pipeline advances on the RELEASE exit cycle.
- A multi-cycle op therefore sees exactly MUL_LAT freeze cycles when mem_busy=0.
- Counters:
  - stall_cnt increments on every cycle with hold_pc=1.
  - flush_cnt increments on every cycle with flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-MULTI returns to RUN. The EXE op is discarded by the stage registers' own reset.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined: a forwarding unit exists. hz uses the load-use term only.
- Undefined: hz also includes (exe_wb_en && match(exe_dest)) || (mem_wb_en && match(mem_dest)). RAW hazards stall until the producer reaches WB.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum ST_RUN/ST_MULTI/ST_RELEASE;
  - REG_ZERO=5'd0;
  - a default for MUL_LAT.
- One sub-module, sat_counter (width CNT_W, inc, rst), instantiated twice.
- Hazard compare and the FSM stay in the top module.

Test Plan:
- Load-use: exe_mem_r_en=1, exe_dest=5, id_src1=5, nothing else active -> exactly 1 cycle of bubble_idex=hold_pc=hold_ifid=1; stall_cnt=1.
- Branch with hazard: branch_taken=1 and a load-use match on id_src2=7 with id_two_src=1 -> flush=1, bubble_idex=0; flush_cnt=1.
- Zero register: exe_dest=0, id_src1=0, exe_mem_r_en=1 -> no bubble.
- Multi-cycle op: exe_multi=1 held with MUL_LAT=4 -> freeze=1 for 4 cycles, then 1 RELEASE cycle with freeze=0, then RUN. A new exe_multi re-enters correctly.
- Memory wait during multi: mem_busy=1 for 6 cycles starting in the 2nd MULTI cycle -> freeze stays 1 until mem_busy drops; no flush or bubble meanwhile; RELEASE exits the cycle mem_busy=0.
- Reset and configuration:
  - rst asserted in MULTI -> next cycle state RUN, counters 0, outputs 0.
  - Without PIPE_FWD_EN: mem_wb_en=1, mem_dest=3, id_src1=3 -> bubble_idex=1. With PIPE_FWD_EN the same stimulus gives bubble_idex=0.
